// File: rtl/preprocessor_sequencer.sv
// preprocessor_sequencer
//
// Sits directly upstream of the attitude preprocessor and sequences it.
// The sequencer takes one raw accelerometer/magnetometer sample and holds it
// stable on the preprocessor inputs. It then pulses the accelerometer load and
// captures roll/pitch on the first done edge. Next it pulses the magnetometer
// load and captures yaw. Finally it presents the angle triple to the Kalman
// stage over a valid/ready handshake.
//
// Optional feature: define PREPROC_SEQ_TIMEOUT_EN to abort a wait state after
// TIMEOUT_CYCLES cycles without a done edge. An abort sets the sticky
// timeout_err_out flag. Without the macro the wait states wait indefinitely,
// timeout_err_out is tied low and clear_err_in is ignored.
//
// Parameters:
//   SETTLE_CYCLES   cycles (>=1) the held inputs stay stable before each load
//   TIMEOUT_CYCLES  wait-state cycles before abort (>=1, 16-bit counter)
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   sample_valid_in / _ready_out   raw sample handshake (ready only in IDLE)
//   acc_{x,y,z}_raw_in, mag_{x,y}_raw_in, declination_cfg_in   raw sample words
//   acc_{x,y,z}_out, mag_{x,y}_out, declination_out            held words
//   load_acc_out, load_mag_out     one-cycle load pulses to the preprocessor
//   data_done_in                   preprocessor done (rising edge is used)
//   roll/pitch/yaw_angle_in        preprocessor results
//   angles_valid_out / _ready_in   angle triple handshake to the Kalman stage
//   roll_out, pitch_out, yaw_out   captured angle triple
//   timeout_err_out, clear_err_in  sticky abort flag and its clear
module preprocessor_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid_in,
  output logic        sample_ready_out,
  input  logic [15:0] acc_x_raw_in,
  input  logic [15:0] acc_y_raw_in,
  input  logic [15:0] acc_z_raw_in,
  input  logic [15:0] mag_x_raw_in,
  input  logic [15:0] mag_y_raw_in,
  input  logic [15:0] declination_cfg_in,
  output logic [15:0] acc_x_out,
  output logic [15:0] acc_y_out,
  output logic [15:0] acc_z_out,
  output logic [15:0] mag_x_out,
  output logic [15:0] mag_y_out,
  output logic [15:0] declination_out,
  output logic        load_acc_out,
  output logic        load_mag_out,
  input  logic        data_done_in,
  input  logic [15:0] roll_angle_in,
  input  logic [15:0] pitch_angle_in,
  input  logic [15:0] yaw_angle_in,
  output logic        angles_valid_out,
  input  logic        angles_ready_in,
  output logic [15:0] roll_out,
  output logic [15:0] pitch_out,
  output logic [15:0] yaw_out,
  output logic        timeout_err_out,
  input  logic        clear_err_in
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_A,
    LOAD_ACC,
    WAIT_ACC,
    SETTLE_M,
    LOAD_MAG,
    WAIT_MAG,
    PRESENT
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] settle_cnt;
  logic        done_prev;
  logic        done_rise;
  logic        accept;
  logic        in_settle;
  logic        settle_last;
  logic        cap_acc;
  logic        cap_mag;
  logic        timeout_hit;

  assign accept      = sample_valid_in && (state == IDLE);
  // A done level left over from an earlier operation has done_prev = 1, so it
  // never counts as completion. Only a fresh 0->1 transition does.
  assign done_rise   = data_done_in && !done_prev;
  assign in_settle   = (state == SETTLE_A) || (state == SETTLE_M);
  assign settle_last = in_settle && (settle_cnt == SETTLE_LAST);
  assign cap_acc     = (state == WAIT_ACC) && done_rise;
  assign cap_mag     = (state == WAIT_MAG) && done_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A done edge wins over a timeout that expires in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)      state_nxt = SETTLE_A;
      SETTLE_A: if (settle_last) state_nxt = LOAD_ACC;
      LOAD_ACC:                  state_nxt = WAIT_ACC;
      WAIT_ACC: begin
        if (done_rise)        state_nxt = SETTLE_M;
        else if (timeout_hit) state_nxt = IDLE;
      end
      SETTLE_M: if (settle_last) state_nxt = LOAD_MAG;
      LOAD_MAG:                  state_nxt = WAIT_MAG;
      WAIT_MAG: begin
        if (done_rise)        state_nxt = PRESENT;
        else if (timeout_hit) state_nxt = IDLE;
      end
      PRESENT:  if (angles_ready_in) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // The counter sits at zero outside the settle states, so each settle state
  // starts counting from zero on entry without an explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (in_settle && !settle_last) begin
      settle_cnt <= settle_cnt + 16'd1;
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= data_done_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x_out       <= '0;
      acc_y_out       <= '0;
      acc_z_out       <= '0;
      mag_x_out       <= '0;
      mag_y_out       <= '0;
      declination_out <= '0;
      roll_out        <= '0;
      pitch_out       <= '0;
      yaw_out         <= '0;
    end else begin
      if (accept) begin
        acc_x_out       <= acc_x_raw_in;
        acc_y_out       <= acc_y_raw_in;
        acc_z_out       <= acc_z_raw_in;
        mag_x_out       <= mag_x_raw_in;
        mag_y_out       <= mag_y_raw_in;
        declination_out <= declination_cfg_in;
      end
      if (cap_acc) begin
        roll_out  <= roll_angle_in;
        pitch_out <= pitch_angle_in;
      end
      if (cap_mag) begin
        yaw_out <= yaw_angle_in;
      end
    end
  end

`ifdef PREPROC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        in_wait;
  logic [15:0] wait_cnt;
  logic        err_flag;

  assign in_wait     = (state == WAIT_ACC) || (state == WAIT_MAG);
  assign timeout_hit = in_wait && !done_rise && (wait_cnt == TIMEOUT_LAST);

  // The counter is zero outside the wait states. Each wait state therefore
  // begins a fresh count and lasts at most TIMEOUT_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (in_wait && !done_rise && !timeout_hit) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // A new abort takes priority over a clear requested in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (timeout_hit) begin
      err_flag <= 1'b1;
    end else if (clear_err_in) begin
      err_flag <= 1'b0;
    end
  end

  assign timeout_err_out = err_flag;
`else
  logic unused_clear_err;

  assign timeout_hit      = 1'b0;
  assign timeout_err_out  = 1'b0;
  assign unused_clear_err = clear_err_in;
`endif

  assign sample_ready_out = (state == IDLE);
  assign load_acc_out     = (state == LOAD_ACC);
  assign load_mag_out     = (state == LOAD_MAG);
  assign angles_valid_out = (state == PRESENT);

endmodule

// File: tb/tb_preprocessor_sequencer.sv
// Testbench for preprocessor_sequencer.
// The bench plays the preprocessor and the Kalman stage itself.
// Expected hold words, angles and pulse edges come from a small model that
// works in absolute edge numbers and sample values.
module tb_preprocessor_sequencer;

  localparam int S  = 2;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid_in;
  logic        sample_ready_out;
  logic [15:0] acc_x_raw_in, acc_y_raw_in, acc_z_raw_in;
  logic [15:0] mag_x_raw_in, mag_y_raw_in, declination_cfg_in;
  logic [15:0] acc_x_out, acc_y_out, acc_z_out;
  logic [15:0] mag_x_out, mag_y_out, declination_out;
  logic        load_acc_out, load_mag_out;
  logic        data_done_in;
  logic [15:0] roll_angle_in, pitch_angle_in, yaw_angle_in;
  logic        angles_valid_out;
  logic        angles_ready_in;
  logic [15:0] roll_out, pitch_out, yaw_out;
  logic        timeout_err_out;
  logic        clear_err_in;

  preprocessor_sequencer #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sample_valid_in   (sample_valid_in),
    .sample_ready_out  (sample_ready_out),
    .acc_x_raw_in      (acc_x_raw_in),
    .acc_y_raw_in      (acc_y_raw_in),
    .acc_z_raw_in      (acc_z_raw_in),
    .mag_x_raw_in      (mag_x_raw_in),
    .mag_y_raw_in      (mag_y_raw_in),
    .declination_cfg_in(declination_cfg_in),
    .acc_x_out         (acc_x_out),
    .acc_y_out         (acc_y_out),
    .acc_z_out         (acc_z_out),
    .mag_x_out         (mag_x_out),
    .mag_y_out         (mag_y_out),
    .declination_out   (declination_out),
    .load_acc_out      (load_acc_out),
    .load_mag_out      (load_mag_out),
    .data_done_in      (data_done_in),
    .roll_angle_in     (roll_angle_in),
    .pitch_angle_in    (pitch_angle_in),
    .yaw_angle_in      (yaw_angle_in),
    .angles_valid_out  (angles_valid_out),
    .angles_ready_in   (angles_ready_in),
    .roll_out          (roll_out),
    .pitch_out         (pitch_out),
    .yaw_out           (yaw_out),
    .timeout_err_out   (timeout_err_out),
    .clear_err_in      (clear_err_in)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] stim [6];
  logic [15:0] m_hold [6];
  logic [15:0] m_roll, m_pitch, m_yaw;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkHolds(input string tag);
    checkOutput({tag, ".acc_x"}, acc_x_out, m_hold[0]);
    checkOutput({tag, ".acc_y"}, acc_y_out, m_hold[1]);
    checkOutput({tag, ".acc_z"}, acc_z_out, m_hold[2]);
    checkOutput({tag, ".mag_x"}, mag_x_out, m_hold[3]);
    checkOutput({tag, ".mag_y"}, mag_y_out, m_hold[4]);
    checkOutput({tag, ".decl"}, declination_out, m_hold[5]);
  endtask

  task automatic checkAngles(input string tag);
    checkOutput({tag, ".roll"}, roll_out, m_roll);
    checkOutput({tag, ".pitch"}, pitch_out, m_pitch);
    checkOutput({tag, ".yaw"}, yaw_out, m_yaw);
  endtask

  task automatic driveWords();
    acc_x_raw_in       = stim[0];
    acc_y_raw_in       = stim[1];
    acc_z_raw_in       = stim[2];
    mag_x_raw_in       = stim[3];
    mag_y_raw_in       = stim[4];
    declination_cfg_in = stim[5];
  endtask

  task automatic randomStim();
    for (int i = 0; i < 6; i++) stim[i] = 16'($urandom);
  endtask

  // Offers the sample in stim, waits until it is accepted and then plays
  // the preprocessor. The done edge for the accelerometer comes d_acc cycles
  // into WAIT_ACC and the one for the magnetometer d_mag cycles into
  // WAIT_MAG. The Kalman stage holds ready low for bp cycles. The stale
  // option holds done high from SETTLE_A into WAIT_ACC. The keep_valid
  // option offers a fresh sample straight after acceptance.
  task automatic applyStimulus(input int d_acc, input int d_mag, input int bp,
                               input bit stale, input bit keep_valid,
                               input logic [15:0] r, input logic [15:0] p,
                               input logic [15:0] y);
    int t_acc, t_d, n;
    sample_valid_in = 1'b1;
    driveWords();
    n = 0;
    while (sample_ready_out !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 16'(sample_ready_out), 16'd1);
    t_acc = edge_n + 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) m_hold[i] = stim[i];
    randomStim();
    driveWords();
    if (!keep_valid) sample_valid_in = 1'b0;
    if (stale) data_done_in = 1'b1;
    checkOutput("ready_low", 16'(sample_ready_out), 16'd0);
    checkHolds("hold");

    for (int k = 0; k <= S + 1; k++) begin
      if (k != 0) @(negedge clk);
      checkOutput("load_acc", 16'(load_acc_out), 16'(edge_n == t_acc + S));
      checkOutput("load_mag_quiet", 16'(load_mag_out), 16'd0);
    end

    for (int k = 0; k < d_acc; k++) begin
      @(negedge clk);
      checkOutput("wait_acc_roll", roll_out, m_roll);
      checkOutput("wait_acc_err", 16'(timeout_err_out), 16'd0);
      checkOutput("wait_acc_noload", 16'(load_acc_out | load_mag_out), 16'd0);
    end
    if (stale) begin
      data_done_in = 1'b0;
      @(negedge clk);
      checkOutput("stale_no_capture", roll_out, m_roll);
      checkOutput("stale_no_mag", 16'(load_mag_out), 16'd0);
    end
    roll_angle_in  = r;
    pitch_angle_in = p;
    data_done_in   = 1'b1;
    t_d = edge_n + 1;
    @(negedge clk);
    data_done_in   = 1'b0;
    roll_angle_in  = 16'($urandom);
    pitch_angle_in = 16'($urandom);
    m_roll  = r;
    m_pitch = p;
    checkAngles("cap_acc");

    for (int k = 0; k <= S + 1; k++) begin
      if (k != 0) @(negedge clk);
      checkOutput("load_mag", 16'(load_mag_out), 16'(edge_n == t_d + S));
      checkOutput("load_acc_quiet", 16'(load_acc_out), 16'd0);
    end

    for (int k = 0; k < d_mag; k++) begin
      @(negedge clk);
      checkOutput("wait_mag_valid", 16'(angles_valid_out), 16'd0);
      checkOutput("wait_mag_yaw", yaw_out, m_yaw);
    end
    yaw_angle_in = y;
    data_done_in = 1'b1;
    @(negedge clk);
    data_done_in = 1'b0;
    yaw_angle_in = 16'($urandom);
    m_yaw = y;
    checkOutput("valid_rise", 16'(angles_valid_out), 16'd1);
    checkAngles("present");

    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", 16'(angles_valid_out), 16'd1);
      checkOutput("bp_ready_out", 16'(sample_ready_out), 16'd0);
      checkAngles("bp");
      checkHolds("bp_hold");
    end
    angles_ready_in = 1'b1;
    @(negedge clk);
    angles_ready_in = 1'b0;
    checkOutput("hs_valid_drop", 16'(angles_valid_out), 16'd0);
    checkOutput("hs_idle", 16'(sample_ready_out), 16'd1);
    checkHolds("hs_hold");
    checkAngles("hs");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t_acc;
    rst = 1'b1;
    sample_valid_in = 1'b0;
    data_done_in = 1'b0;
    angles_ready_in = 1'b0;
    clear_err_in = 1'b0;
    roll_angle_in = '0;
    pitch_angle_in = '0;
    yaw_angle_in = '0;
    for (int i = 0; i < 6; i++) begin
      stim[i] = '0;
      m_hold[i] = '0;
    end
    driveWords();
    m_roll = '0;
    m_pitch = '0;
    m_yaw = '0;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkHolds("reset");
    checkAngles("reset");
    checkOutput("reset_ready", 16'(sample_ready_out), 16'd1);
    checkOutput("reset_strobes", 16'({load_acc_out, load_mag_out, angles_valid_out, timeout_err_out}), 16'd0);

    $display("[TB] nominal cycle");
    stim[0] = 16'd100;
    stim[1] = 16'hFF38;
    stim[2] = 16'd16384;
    stim[3] = 16'd300;
    stim[4] = 16'hFFCE;
    stim[5] = 16'd0;
    applyStimulus(5, 5, 0, 1'b0, 1'b0, 16'h0123, 16'hFF10, 16'h0456);

    $display("[TB] backpressure");
    randomStim();
    applyStimulus(3, 4, 10, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));

    $display("[TB] stale done");
    randomStim();
    applyStimulus(6, 2, 1, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));

    $display("[TB] back-to-back");
    randomStim();
    applyStimulus(2, 2, 2, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    applyStimulus(4, 3, 0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));

    $display("[TB] randomized transactions");
    for (int i = 0; i < 5; i++) begin
      randomStim();
      applyStimulus(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)),
                    int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)), 1'b0,
                    16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("[TB] async reset mid WAIT_ACC");
    randomStim();
    sample_valid_in = 1'b1;
    driveWords();
    @(negedge clk);
    sample_valid_in = 1'b0;
    for (int i = 0; i < 6; i++) m_hold[i] = stim[i];
    checkHolds("pre_reset_hold");
    repeat (S + 1) @(negedge clk);
    checkOutput("pre_reset_busy", 16'(sample_ready_out), 16'd0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) m_hold[i] = '0;
    m_roll = '0;
    m_pitch = '0;
    m_yaw = '0;
    checkHolds("async_reset");
    checkAngles("async_reset");
    checkOutput("async_reset_ready", 16'(sample_ready_out), 16'd1);
    checkOutput("async_reset_strobes", 16'({load_acc_out, load_mag_out, angles_valid_out}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      data_done_in = (k == 2);
      roll_angle_in = 16'($urandom);
      @(negedge clk);
      checkOutput("post_reset_strobes", 16'({load_acc_out, load_mag_out, angles_valid_out}), 16'd0);
      checkOutput("post_reset_roll", roll_out, m_roll);
      checkOutput("post_reset_idle", 16'(sample_ready_out), 16'd1);
    end
    data_done_in = 1'b0;

`ifdef PREPROC_SEQ_TIMEOUT_EN
    $display("[TB] timeout");
    randomStim();
    applyStimulus(3, 3, 0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    randomStim();
    sample_valid_in = 1'b1;
    driveWords();
    @(negedge clk);
    sample_valid_in = 1'b0;
    t_acc = edge_n;
    for (int i = 0; i < 6; i++) m_hold[i] = stim[i];
    repeat (S + 1) @(negedge clk);
    for (int k = 0; k <= TO; k++) begin
      if (k != 0) @(negedge clk);
      checkOutput("to_err", 16'(timeout_err_out), 16'(edge_n == t_acc + S + 1 + TO));
      checkOutput("to_idle", 16'(sample_ready_out), 16'(edge_n == t_acc + S + 1 + TO));
      checkOutput("to_no_valid", 16'(angles_valid_out), 16'd0);
    end
    checkAngles("to_angles");
    checkHolds("to_hold");
    @(negedge clk);
    checkOutput("to_sticky", 16'(timeout_err_out), 16'd1);
    clear_err_in = 1'b1;
    @(negedge clk);
    clear_err_in = 1'b0;
    checkOutput("to_cleared", 16'(timeout_err_out), 16'd0);
`else
    $display("[TB] long wait without timeout");
    t_acc = 0;
    clear_err_in = 1'b1;
    randomStim();
    applyStimulus(40, 30, 0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    clear_err_in = 1'b0;
    checkOutput("no_timeout_err", 16'(timeout_err_out), 16'(t_acc));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
